// File: rtl/ldl_p2ram_fifo_ctrl_pkg.sv
// Shared helpers for the FIFO controller slice: pointer wrap arithmetic that
// works for any depth, not only powers of two.
package ldl_p2ram_fifo_ctrl_pkg;

    // Increment v and return to 0 after max-1; no masking, so any max >= 2 works.
    function automatic int unsigned wrap_inc(input int unsigned v, input int unsigned max);
        if (v >= max - 1) begin
            return 0;
        end
        return v + 1;
    endfunction

endpackage

// File: rtl/ldl_p2ram_fifo_ctrl_wrap_cnt.sv
// Modulo-MAX up-counter used for the RAM write and read pointers.
module ldl_wrap_cnt
    import ldl_p2ram_fifo_ctrl_pkg::*;
#(
    parameter int MAX = 10
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clr,
    input  logic                   inc,
    output logic [$clog2(MAX)-1:0] value
);

    localparam int W = $clog2(MAX);

    logic [W-1:0] value_d;
    logic [W-1:0] value_q;

    always_comb begin
        value_d = value_q;
        if (clr) begin
            value_d = '0;
        end else if (inc) begin
            value_d = W'(wrap_inc(32'(value_q), MAX));
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            value_q <= '0;
        end else begin
            value_q <= value_d;
        end
    end

    assign value = value_q;

endmodule

// File: rtl/ldl_p2ram_fifo_ctrl.sv
// First-word-fall-through FIFO controller for an external simple dual-port RAM
// whose registered read port doubles as the FIFO output register.
module ldl_p2ram_fifo_ctrl
    import ldl_p2ram_fifo_ctrl_pkg::*;
#(
    parameter int DW    = 8,
    parameter int DEPTH = 10,
    parameter int AW    = $clog2(DEPTH),
    parameter int CW    = $clog2(DEPTH + 2),
    parameter int AFULL = DEPTH - 2
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          flush,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          ram_we,
    output logic [AW-1:0] ram_wa,
    output logic [DW-1:0] ram_din,
    output logic          ram_re,
    output logic [AW-1:0] ram_ra,
    input  logic [DW-1:0] ram_dout,
    output logic [CW-1:0] count,
    output logic          afull
);

    logic [CW-1:0] ram_cnt_d;
    logic [CW-1:0] ram_cnt_q;
    logic          ovld_d;
    logic          ovld_q;
    logic          afull_d;
    logic          afull_q;
    logic [CW-1:0] count_next;
    logic          push;
    logic          ptr_clr;

    // Ready comes from registered occupancy only: a full RAM refuses a push
    // even when the head is being popped in the same cycle.
    assign in_ready = rst_n & (ram_cnt_q != CW'(DEPTH));
    assign push     = in_valid & in_ready & ~flush;
    assign ram_re   = rst_n & ~flush & (ram_cnt_q != '0) & (~ovld_q | out_ready);
    assign ptr_clr  = flush;

    assign ram_we   = push;
    assign ram_din  = in_data;
    assign out_data = ram_dout;

    always_comb begin
        ram_cnt_d  = ram_cnt_q + CW'(push) - CW'(ram_re);
        ovld_d     = ram_re | (ovld_q & ~out_ready);
        if (flush) begin
            ram_cnt_d = '0;
            ovld_d    = 1'b0;
        end
        count_next = ram_cnt_d + CW'(ovld_d);
        afull_d    = ~flush & (count_next >= CW'(AFULL));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ram_cnt_q <= '0;
            ovld_q    <= 1'b0;
            afull_q   <= 1'b0;
        end else begin
            ram_cnt_q <= ram_cnt_d;
            ovld_q    <= ovld_d;
            afull_q   <= afull_d;
        end
    end

    ldl_wrap_cnt #(.MAX(DEPTH)) u_wptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .inc   (push),
        .value (ram_wa)
    );

    ldl_wrap_cnt #(.MAX(DEPTH)) u_rptr (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (ptr_clr),
        .inc   (ram_re),
        .value (ram_ra)
    );

    // Head flag and occupancy read as empty for the whole time reset is held.
    assign out_valid = rst_n & ovld_q;
    assign count     = rst_n ? (ram_cnt_q + CW'(ovld_q)) : '0;
    assign afull     = afull_q;

endmodule

// File: tb/tb_ldl_p2ram_fifo_ctrl.sv
// Randomized self-checking bench for ldl_p2ram_fifo_ctrl with a behavioural
// RAM and a queue-based reference model of the FIFO contents.
module tb_ldl_p2ram_fifo_ctrl;

    localparam int DW    = 8;
    localparam int DEPTH = 10;
    localparam int AW    = $clog2(DEPTH);
    localparam int CW    = $clog2(DEPTH + 2);
    localparam int AFULL = DEPTH - 2;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          flush;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_data;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          ram_we;
    logic [AW-1:0] ram_wa;
    logic [DW-1:0] ram_din;
    logic          ram_re;
    logic [AW-1:0] ram_ra;
    logic [DW-1:0] ram_dout;
    logic [CW-1:0] count;
    logic          afull;

    always #5 clk = ~clk;

    ldl_p2ram_fifo_ctrl #(.DW(DW), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .ram_we    (ram_we),
        .ram_wa    (ram_wa),
        .ram_din   (ram_din),
        .ram_re    (ram_re),
        .ram_ra    (ram_ra),
        .ram_dout  (ram_dout),
        .count     (count),
        .afull     (afull)
    );

    // Simple dual-port RAM: registered read, dout holds when not reading.
    logic [DW-1:0] mem [DEPTH];
    always @(posedge clk) begin
        if (ram_we && ram_wa < AW'(DEPTH)) mem[ram_wa] <= ram_din;
        if (ram_re) ram_dout <= (ram_ra < AW'(DEPTH)) ? mem[ram_ra] : 'x;
    end

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: FIFO as a queue of RAM entries plus one head register.
    int q_ram[$];
    bit m_hv;
    int m_hd;
    int m_wcnt;
    int m_rcnt;
    bit m_afull;
    int max_ram_fill;

    task automatic model_clear();
        q_ram.delete();
        m_hv    = 1'b0;
        m_wcnt  = 0;
        m_rcnt  = 0;
        m_afull = 1'b0;
    endtask

    task automatic step(input bit rn, input bit fl, input bit iv, input int id, input bit ordy);
        bit e_rdy, e_push, e_re, e_ov;
        int e_cnt;
        rst_n     = rn;
        flush     = fl;
        in_valid  = iv;
        in_data   = DW'(id);
        out_ready = ordy;
        @(negedge clk);
        e_rdy  = rn && (q_ram.size() != DEPTH);
        e_push = iv && e_rdy && !fl;
        e_re   = rn && !fl && (q_ram.size() != 0) && (!m_hv || ordy);
        e_ov   = rn && m_hv;
        e_cnt  = rn ? q_ram.size() + int'(m_hv) : 0;
        chk("in_ready", 32'(in_ready), 32'(e_rdy));
        chk("ram_we", 32'(ram_we), 32'(e_push));
        chk("ram_re", 32'(ram_re), 32'(e_re));
        chk("out_valid", 32'(out_valid), 32'(e_ov));
        chk("count", 32'(count), 32'(e_cnt));
        chk("afull", 32'(afull), 32'(m_afull));
        if (e_push) begin
            chk("ram_wa", 32'(ram_wa), 32'(m_wcnt % DEPTH));
            chk("ram_din", 32'(ram_din), 32'(id & 8'hFF));
        end
        if (e_re) chk("ram_ra", 32'(ram_ra), 32'(m_rcnt % DEPTH));
        if (e_ov) chk("out_data", 32'(out_data), 32'(m_hd));
        if (!rn || fl) begin
            model_clear();
        end else begin
            if (e_re) begin
                m_hd = q_ram.pop_front();
                m_hv = 1'b1;
                m_rcnt++;
            end else if (ordy) begin
                m_hv = 1'b0;
            end
            if (e_push) begin
                q_ram.push_back(id & 8'hFF);
                m_wcnt++;
            end
            m_afull = (q_ram.size() + int'(m_hv)) >= AFULL;
        end
        if (q_ram.size() > max_ram_fill) max_ram_fill = q_ram.size();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int bias;
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_data = '0; out_ready = 1'b0;
        model_clear();
        max_ram_fill = 0;
        repeat (2) @(posedge clk);
        #1;

        // Single push, fall-through after two edges.
        step(1, 0, 1, 8'hA5, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);
        step(1, 0, 0, 0, 0);

        // Fill to capacity with the head stalled; the 12th push is refused.
        for (int i = 1; i <= 12; i++) step(1, 0, 1, i, 0);
        chk("full_in_ready", 32'(in_ready), 32'd0);
        chk("full_count", 32'(count), 32'd11);
        chk("full_afull", 32'(afull), 32'd1);

        // Drain in order.
        for (int i = 0; i < 13; i++) step(1, 0, 0, 0, 1);
        chk("empty_count", 32'(count), 32'd0);

        // Sustained streaming, pointers wrap several times.
        max_ram_fill = 0;
        for (int i = 0; i < 40; i++) step(1, 0, 1, 8'h40 + i, 1);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 1);
        chk("stream_ram_fill", 32'(max_ram_fill <= 1), 32'd1);

        // Flush with count=5 while pushing and popping.
        for (int i = 0; i < 5; i++) step(1, 0, 1, 8'h70 + i, 0);
        step(1, 1, 1, 8'h99, 1);
        chk("flush_count", 32'(count), 32'd0);
        chk("flush_ovld", 32'(out_valid), 32'd0);
        step(1, 0, 1, 8'h5A, 1);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 0);
        step(1, 0, 0, 0, 1);

        // Reset pulse mid-stream with count=7.
        for (int i = 0; i < 7; i++) step(1, 0, 1, 8'h20 + i, 0);
        step(0, 0, 1, 8'hEE, 1);
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_afull", 32'(afull), 32'd0);

        // Random traffic with phases biased toward filling or draining.
        for (int blk = 0; blk < 30; blk++) begin
            bias = $urandom_range(1, 3);
            for (int i = 0; i < 80; i++) begin
                step($urandom_range(0, 199) != 0,
                     $urandom_range(0, 59) == 0,
                     $urandom_range(0, 3) < bias + 1,
                     int'($urandom_range(0, 255)),
                     $urandom_range(0, 3) >= bias);
            end
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
